// File: rtl/ads_frame_packer_pkg.sv
// rtl/ads_frame_packer_pkg.sv - shared state type, header constant and sign-extension helper
package ads_pkg;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hADC0;

    // Left-justify the sample, then arithmetic-shift it back so bit dw-1 fills the top bits.
    function automatic logic [31:0] sign_extend(input logic [31:0] din, input int unsigned dw);
        logic [31:0] v_shl;
        v_shl = din << (32 - dw);
        return $unsigned($signed(v_shl) >>> (32 - dw));
    endfunction

endpackage

// File: rtl/ads_frame_packer_if.sv
// rtl/ads_frame_packer_if.sv - stream bundle (tvalid/tready/tdata/tlast) with master/slave views
interface ads_frame_packer_if #(
    parameter int W = 32
) ();
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/ads_frame_packer_fifo.sv
// rtl/ads_frame_packer_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_rd) begin
                r_count <= r_count + CW'(1);
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ads_frame_packer.sv
// rtl/ads_frame_packer.sv - packs sign-extended ADC samples into header-prefixed fixed-length frames
module ads_frame_packer
    import ads_pkg::*;
#(
    parameter int          DW         = 24,
    parameter int          OW         = 32,
    parameter int          FRAME_LEN  = 256,
    parameter int          FIFO_DEPTH = 512,
    parameter logic [15:0] HDR_MAGIC  = HDR_MAGIC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    ads_frame_packer_if.slave        s_axis,
    ads_frame_packer_if.master       m_axis,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              frame_seq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(FRAME_LEN + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_tvalid;
    logic [OW-1:0]   r_tdata;
    logic            r_tlast;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic [15:0]     r_frame_seq;
    logic            r_ovf;
    logic [15:0]     r_drop_cnt;

    logic            w_accept;
    logic            w_drop;
    logic [OW-1:0]   w_sample;
    logic [OW-1:0]   w_fifo_dout;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;
    logic            w_pop;
    logic            w_hs;
    logic            w_load_hdr;
    logic            w_load_data;
    logic            w_clear_out;
    logic            w_unused_tlast;

    assign s_axis.tready  = 1'b1;
    assign w_unused_tlast = s_axis.tlast;

    assign w_accept = s_axis.tvalid && en;
    assign w_drop   = w_accept && w_fifo_full;
    assign w_sample = sign_extend(32'(s_axis.tdata), DW);

    sync_fifo #(
        .WIDTH (OW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_accept),
        .i_wr_data (w_sample),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_dout),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign w_hs  = r_tvalid && m_axis.tready;
    // The output register is refilled straight from the FIFO head, so a pop coincides with each data load.
    assign w_pop = w_load_data && !w_fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_hdr  = 1'b0;
        w_load_data = 1'b0;
        w_clear_out = 1'b0;
        w_idx_nxt   = (r_state == HDR) ? '0 : r_idx + IW'(1);
        case (r_state)
            IDLE: begin
                if (w_fifo_count >= CW'(FRAME_LEN)) begin
                    w_state_nxt = HDR;
                    w_load_hdr  = 1'b1;
                end
            end
            HDR: begin
                if (w_hs) begin
                    w_state_nxt = DATA;
                    w_load_data = 1'b1;
                end
            end
            DATA: begin
                if (w_hs) begin
                    if (r_tlast) begin
                        w_state_nxt = IDLE;
                        w_clear_out = 1'b1;
                    end else begin
                        w_load_data = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_idx       <= '0;
            r_frame_seq <= '0;
        end else begin
            if (w_load_hdr) begin
                r_tvalid <= 1'b1;
                r_tdata  <= {HDR_MAGIC, r_frame_seq};
                r_tlast  <= 1'b0;
            end else if (w_load_data) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_fifo_dout;
                r_idx    <= w_idx_nxt;
                r_tlast  <= (w_idx_nxt == IW'(FRAME_LEN - 1));
            end else if (w_clear_out) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
            if (r_state == HDR && w_hs) begin
                r_frame_seq <= r_frame_seq + 16'd1;
            end
        end
    end

    // A drop in the same cycle as a clear wins, restarting the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr) begin
                r_drop_cnt <= 16'd1;
            end else if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tlast  = r_tlast;
    assign ovf           = r_ovf;
    assign drop_cnt      = r_drop_cnt;
    assign frame_seq     = r_frame_seq;

endmodule

// File: tb/tb_ads_frame_packer.sv
// tb/tb_ads_frame_packer.sv - randomized self-checking bench for ads_frame_packer
module tb_ads_frame_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b, ovf_clr_a, ovf_clr_b, ovf_a, ovf_b;
    logic [15:0] drop_a, drop_b, seq_a, seq_b;

    always #5 clk = ~clk;

    ads_frame_packer_if #(.W(24)) a_s ();
    ads_frame_packer_if #(.W(32)) a_m ();
    ads_frame_packer_if #(.W(24)) b_s ();
    ads_frame_packer_if #(.W(32)) b_m ();

    ads_frame_packer #(.DW(24), .OW(32), .FRAME_LEN(4), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .s_axis(a_s), .m_axis(a_m),
        .ovf(ovf_a), .ovf_clr(ovf_clr_a), .drop_cnt(drop_a), .frame_seq(seq_a)
    );

    ads_frame_packer #(.DW(24), .OW(32), .FRAME_LEN(8), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .s_axis(b_s), .m_axis(b_m),
        .ovf(ovf_b), .ovf_clr(ovf_clr_b), .drop_cnt(drop_b), .frame_seq(seq_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [32:0] got_a[$];
    int          got_cyc_a[$];
    logic [32:0] got_b[$];
    logic [32:0] exp_a[$];
    logic [31:0] pend_a[$];
    logic [15:0] mseq_a;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!rst && a_m.tvalid && a_m.tready) begin
            got_a.push_back({a_m.tlast, a_m.tdata});
            got_cyc_a.push_back(cyc);
        end
        if (!rst && b_m.tvalid && b_m.tready) begin
            got_b.push_back({b_m.tlast, b_m.tdata});
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] sx24(input logic [23:0] d);
        int v;
        v = int'(d);
        if (v >= 32'h0080_0000) v = v - 32'h0100_0000;
        return 32'(v);
    endfunction

    // Reference: every 4 accepted samples become header + 4 words, tlast on the 4th.
    task automatic model_a(input logic [23:0] d);
        pend_a.push_back(sx24(d));
        if (pend_a.size() == 4) begin
            exp_a.push_back({1'b0, 16'hADC0, mseq_a});
            for (int i = 0; i < 4; i++) exp_a.push_back({(i == 3), pend_a[i]});
            pend_a.delete();
            mseq_a = mseq_a + 16'd1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [23:0] d);
        a_s.tvalid = 1'b1;
        a_s.tdata  = d;
        cycle();
        a_s.tvalid = 1'b0;
        if (en_a) model_a(d);
    endtask

    task automatic push_b(input logic [23:0] d);
        b_s.tvalid = 1'b1;
        b_s.tdata  = d;
        cycle();
        b_s.tvalid = 1'b0;
    endtask

    task automatic clear_a();
        got_a.delete();
        got_cyc_a.delete();
        exp_a.delete();
        pend_a.delete();
    endtask

    task automatic drain_a();
        a_m.tready = 1'b1;
        for (int g = 0; g < 300 && got_a.size() < exp_a.size(); g++) cycle();
        repeat (6) cycle();
    endtask

    task automatic test_reset();
        n_tests++; if (a_m.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b want 0", a_m.tvalid); end
        n_tests++; if (a_m.tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got %b want 0", a_m.tlast); end
        n_tests++; if (a_m.tdata !== 32'h0) begin n_fail++; $display("FAIL rst_tdata got %h want 0", a_m.tdata); end
        n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", ovf_a); end
        n_tests++; if (drop_a !== 16'h0) begin n_fail++; $display("FAIL rst_drop got %h want 0", drop_a); end
        n_tests++; if (seq_a !== 16'h0) begin n_fail++; $display("FAIL rst_seq got %h want 0", seq_a); end
        n_tests++; if (b_m.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_b_tvalid got %b want 0", b_m.tvalid); end
    endtask

    task automatic test_frame_format();
        logic [32:0] want [5];
        logic [23:0] din  [4];
        want = '{33'h0_ADC00000, 33'h0_00000001, 33'h0_FFFFFFFF, 33'h0_007FFFFF, 33'h1_FF800000};
        din  = '{24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000};
        clear_a();
        a_m.tready = 1'b1;
        for (int i = 0; i < 4; i++) push_a(din[i]);
        @(negedge clk);
        n_tests++; if (a_m.tvalid !== 1'b0) begin n_fail++; $display("FAIL fmt_latency1 tvalid got %b want 0", a_m.tvalid); end
        @(negedge clk);
        n_tests++; if (a_m.tvalid !== 1'b1 || a_m.tdata !== 32'hADC00000) begin
            n_fail++; $display("FAIL fmt_latency2 got v=%b d=%h want v=1 d=adc00000", a_m.tvalid, a_m.tdata);
        end
        cycle();
        drain_a();
        n_tests++; if (got_a.size() != 5) begin n_fail++; $display("FAIL fmt_count got %0d want 5", got_a.size()); end
        for (int i = 0; i < 5 && i < got_a.size(); i++) begin
            n_tests++; if (got_a[i] !== want[i]) begin n_fail++; $display("FAIL fmt_word%0d got %h want %h", i, got_a[i], want[i]); end
        end
        n_tests++; if (seq_a !== 16'd1) begin n_fail++; $display("FAIL fmt_seq got %0d want 1", seq_a); end
    endtask

    task automatic test_back_to_back();
        clear_a();
        a_m.tready = 1'b1;
        for (int i = 0; i < 8; i++) push_a(24'($urandom));
        drain_a();
        n_tests++; if (got_a.size() != exp_a.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            n_tests++; if (got_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL b2b_word%0d got %h want %h", i, got_a[i], exp_a[i]); end
        end
        if (got_cyc_a.size() >= 10) begin
            n_tests++; if (got_cyc_a[4] - got_cyc_a[0] != 4) begin n_fail++; $display("FAIL b2b_stream got %0d want 4", got_cyc_a[4] - got_cyc_a[0]); end
            n_tests++; if (got_cyc_a[5] - got_cyc_a[4] != 2) begin n_fail++; $display("FAIL b2b_bubble got %0d want 2", got_cyc_a[5] - got_cyc_a[4]); end
        end
    endtask

    task automatic test_backpressure();
        int g;
        clear_a();
        a_m.tready = 1'b1;
        for (int i = 0; i < 4; i++) push_a(24'($urandom));
        g = 0;
        while (got_a.size() < 2 && g < 50) begin cycle(); g++; end
        n_tests++; if (got_a.size() < 2) begin n_fail++; $display("FAIL bp_start got %0d want 2", got_a.size()); end
        a_m.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if (a_m.tvalid !== 1'b1 || {a_m.tlast, a_m.tdata} !== exp_a[2]) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%b %h want v=1 %h", i, a_m.tvalid, {a_m.tlast, a_m.tdata}, exp_a[2]);
            end
            cycle();
        end
        drain_a();
        n_tests++; if (got_a.size() != exp_a.size()) begin n_fail++; $display("FAIL bp_count got %0d want %0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            n_tests++; if (got_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL bp_word%0d got %h want %h", i, got_a[i], exp_a[i]); end
        end
    endtask

    task automatic test_random_stream();
        clear_a();
        for (int i = 0; i < 16; i++) begin
            a_m.tready = ($urandom_range(0, 3) != 0);
            push_a(24'($urandom));
            for (int k = 0; k < int'($urandom_range(2, 4)); k++) begin
                a_m.tready = ($urandom_range(0, 3) != 0);
                cycle();
            end
        end
        drain_a();
        n_tests++; if (got_a.size() != exp_a.size()) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            n_tests++; if (got_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL rnd_word%0d got %h want %h", i, got_a[i], exp_a[i]); end
        end
        n_tests++; if (drop_a !== 16'h0) begin n_fail++; $display("FAIL rnd_drop got %0d want 0", drop_a); end
    endtask

    task automatic test_seq_wrap();
        clear_a();
        force dut_a.r_frame_seq = 16'hFFFF;
        cycle();
        release dut_a.r_frame_seq;
        mseq_a = 16'hFFFF;
        n_tests++; if (seq_a !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", seq_a); end
        for (int i = 0; i < 8; i++) push_a(24'($urandom));
        drain_a();
        n_tests++; if (got_a.size() != 10) begin n_fail++; $display("FAIL wrap_count got %0d want 10", got_a.size()); end
        if (got_a.size() >= 10) begin
            n_tests++; if (got_a[0][31:0] !== 32'hADC0FFFF) begin n_fail++; $display("FAIL wrap_hdr0 got %h want adc0ffff", got_a[0][31:0]); end
            n_tests++; if (got_a[5][31:0] !== 32'hADC00000) begin n_fail++; $display("FAIL wrap_hdr1 got %h want adc00000", got_a[5][31:0]); end
        end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            n_tests++; if (got_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_word%0d got %h want %h", i, got_a[i], exp_a[i]); end
        end
        n_tests++; if (seq_a !== 16'd1) begin n_fail++; $display("FAIL wrap_seq got %h want 1", seq_a); end
    endtask

    task automatic test_reset_mid_frame();
        int g;
        clear_a();
        a_m.tready = 1'b1;
        for (int i = 0; i < 4; i++) push_a(24'($urandom));
        g = 0;
        while (got_a.size() < 3 && g < 50) begin cycle(); g++; end
        n_tests++; if (a_m.tvalid !== 1'b1 || {a_m.tlast, a_m.tdata} !== exp_a[3]) begin
            n_fail++; $display("FAIL rmf_idx2 got v=%b %h want v=1 %h", a_m.tvalid, {a_m.tlast, a_m.tdata}, exp_a[3]);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_tests++; if (a_m.tvalid !== 1'b0) begin n_fail++; $display("FAIL rmf_tvalid got %b want 0", a_m.tvalid); end
        n_tests++; if (dut_a.w_fifo_count !== 4'd0) begin n_fail++; $display("FAIL rmf_fifo got %0d want 0", dut_a.w_fifo_count); end
        n_tests++; if (seq_a !== 16'h0) begin n_fail++; $display("FAIL rmf_seq got %h want 0", seq_a); end
        n_tests++; if (got_a.size() != 3) begin n_fail++; $display("FAIL rmf_partial got %0d want 3", got_a.size()); end
        clear_a();
        mseq_a = 16'h0;
        for (int i = 0; i < 4; i++) push_a(24'($urandom));
        drain_a();
        n_tests++; if (got_a.size() != 5) begin n_fail++; $display("FAIL rmf_count got %0d want 5", got_a.size()); end
        if (got_a.size() >= 1) begin
            n_tests++; if (got_a[0] !== 33'h0_ADC00000) begin n_fail++; $display("FAIL rmf_hdr got %h want adc00000", got_a[0]); end
        end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            n_tests++; if (got_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL rmf_word%0d got %h want %h", i, got_a[i], exp_a[i]); end
        end
    endtask

    task automatic test_enable_gating();
        int n_last;
        clear_a();
        a_m.tready = 1'b1;
        en_a = 1'b0;
        for (int i = 0; i < 20; i++) push_a(24'($urandom));
        repeat (10) cycle();
        n_tests++; if (got_a.size() != 0) begin n_fail++; $display("FAIL en_output got %0d want 0", got_a.size()); end
        n_tests++; if (drop_a !== 16'h0) begin n_fail++; $display("FAIL en_drop got %0d want 0", drop_a); end
        en_a = 1'b1;
        for (int i = 0; i < 4; i++) push_a(24'($urandom));
        drain_a();
        n_tests++; if (got_a.size() != 5) begin n_fail++; $display("FAIL en_count got %0d want 5", got_a.size()); end
        n_last = 0;
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            if (got_a[i][32]) n_last++;
            n_tests++; if (got_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL en_word%0d got %h want %h", i, got_a[i], exp_a[i]); end
        end
        n_tests++; if (n_last != 1) begin n_fail++; $display("FAIL en_frames got %0d want 1", n_last); end
    endtask

    task automatic test_overflow();
        logic [31:0] kept[$];
        logic [23:0] d;
        int          occ;
        got_b.delete();
        b_m.tready = 1'b0;
        occ = 0;
        for (int i = 0; i < 10; i++) begin
            d = 24'($urandom);
            if (occ < 8) begin kept.push_back(sx24(d)); occ++; end
            push_b(d);
        end
        n_tests++; if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", ovf_b); end
        n_tests++; if (drop_b !== 16'd2) begin n_fail++; $display("FAIL ovf_drop got %0d want 2", drop_b); end
        ovf_clr_b = 1'b1;
        push_b(24'($urandom));
        ovf_clr_b = 1'b0;
        n_tests++; if (ovf_b !== 1'b1 || drop_b !== 16'd1) begin
            n_fail++; $display("FAIL ovf_clr_race got ovf=%b drop=%0d want ovf=1 drop=1", ovf_b, drop_b);
        end
        ovf_clr_b = 1'b1;
        cycle();
        ovf_clr_b = 1'b0;
        n_tests++; if (ovf_b !== 1'b0 || drop_b !== 16'd0) begin
            n_fail++; $display("FAIL ovf_clr got ovf=%b drop=%0d want ovf=0 drop=0", ovf_b, drop_b);
        end
        b_m.tready = 1'b1;
        for (int g = 0; g < 100 && got_b.size() < 9; g++) cycle();
        repeat (6) cycle();
        n_tests++; if (got_b.size() != 9) begin n_fail++; $display("FAIL ovf_count got %0d want 9", got_b.size()); end
        if (got_b.size() >= 1) begin
            n_tests++; if (got_b[0] !== 33'h0_ADC00000) begin n_fail++; $display("FAIL ovf_hdr got %h want adc00000", got_b[0]); end
        end
        for (int i = 0; i < 8 && i + 1 < got_b.size(); i++) begin
            n_tests++; if (got_b[i+1] !== {(i == 7), kept[i]}) begin
                n_fail++; $display("FAIL ovf_word%0d got %h want %h", i, got_b[i+1], {(i == 7), kept[i]});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b1; en_b = 1'b1;
        ovf_clr_a = 1'b0; ovf_clr_b = 1'b0;
        a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tlast = 1'b0;
        b_s.tvalid = 1'b0; b_s.tdata = '0; b_s.tlast = 1'b0;
        a_m.tready = 1'b1; b_m.tready = 1'b1;
        mseq_a = 16'h0;
        repeat (3) cycle();
        rst = 1'b0;
        test_reset();
        test_frame_format();
        test_back_to_back();
        test_backpressure();
        test_random_stream();
        test_seq_wrap();
        test_reset_mid_frame();
        test_enable_gating();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
